// File: rtl/stopwatch_cmd_arbiter_pkg.sv
// Shared definitions for the stopwatch command arbiter.
//   - command codes carried on o_cmd
//   - FSM state encoding (also exposed on the debug state output)
//   - ASCII bytes recognised as UART commands
package stopwatch_cmd_arbiter_pkg;

   localparam logic [1:0] CMD_NONE     = 2'd0;
   localparam logic [1:0] CMD_RUN_STOP = 2'd1;
   localparam logic [1:0] CMD_CLEAR    = 2'd2;
   localparam logic [1:0] CMD_MODE     = 2'd3;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_R_UP = 8'h52;
   localparam logic [7:0] ASCII_R_LO = 8'h72;
   localparam logic [7:0] ASCII_C_UP = 8'h43;
   localparam logic [7:0] ASCII_C_LO = 8'h63;
   localparam logic [7:0] ASCII_M_UP = 8'h4D;
   localparam logic [7:0] ASCII_M_LO = 8'h6D;

endpackage

// File: rtl/stopwatch_cmd_arbiter_uart_cmd_decode.sv
// UART command decoder: turns a received byte into one of three request strobes.
// Ports:
//   i_rx_data       received byte, meaningful only while i_rx_done=1
//   i_rx_done       one-cycle strobe marking a received byte
//   o_req_run_stop  'R' or 'r' received this cycle
//   o_req_clear     'C' or 'c' received this cycle
//   o_req_mode      'M' or 'm' received this cycle
// Purely combinational; any other byte produces no request.
module uart_cmd_decode
   import stopwatch_cmd_arbiter_pkg::*;
(
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_done,
   output logic       o_req_run_stop,
   output logic       o_req_clear,
   output logic       o_req_mode
);

   always_comb begin
      o_req_run_stop = 1'b0;
      o_req_clear    = 1'b0;
      o_req_mode     = 1'b0;
      if (i_rx_done) begin
         o_req_run_stop = (i_rx_data == ASCII_R_UP) || (i_rx_data == ASCII_R_LO);
         o_req_clear    = (i_rx_data == ASCII_C_UP) || (i_rx_data == ASCII_C_LO);
         o_req_mode     = (i_rx_data == ASCII_M_UP) || (i_rx_data == ASCII_M_LO);
      end
   end

endmodule

// File: rtl/stopwatch_cmd_arbiter.sv
// Stopwatch command arbiter.
// Merges debounced button pulses and UART command bytes into pending flags,
// issues at most one command per cycle (priority clear > run_stop > mode) with a
// minimum spacing of CMD_GAP cycles, and runs the STOP/RUN/CLEAR control FSM.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   i_btn_run_stop   run/stop button pulse
//   i_btn_clear      clear button pulse
//   i_btn_mode       mode button pulse
//   i_rx_data        UART byte, valid while i_rx_done=1
//   i_rx_done        UART byte strobe
//   o_run            1 while the FSM is in RUN
//   o_clear          one-cycle pulse while the FSM is in CLEAR
//   o_mode           display mode, toggled by each mode command
//   o_cmd_valid      one-cycle pulse when a command is issued
//   o_cmd            issued command code, CMD_NONE when nothing issued
//   o_dbg_state      current FSM state (state_t encoding)
// All outputs are registered. A request in cycle n reaches the flags at the end
// of n, is arbitrated in n+1 and shows on the outputs in n+2.
module stopwatch_cmd_arbiter
   import stopwatch_cmd_arbiter_pkg::*;
#(
   parameter int CMD_GAP = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_run_stop,
   input  logic       i_btn_clear,
   input  logic       i_btn_mode,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_done,
   output logic       o_run,
   output logic       o_clear,
   output logic       o_mode,
   output logic       o_cmd_valid,
   output logic [1:0] o_cmd,
   output logic [1:0] o_dbg_state
);

   localparam logic [7:0] GAP_LOAD = 8'(CMD_GAP - 1);

   logic       uart_run_stop, uart_clear, uart_mode;
   logic       req_run_stop, req_clear, req_mode;
   logic       can_issue, issue_run_stop, issue_clear, issue_mode;

   state_t     state_q, state_d;
   logic       pend_run_stop_q, pend_run_stop_d;
   logic       pend_clear_q, pend_clear_d;
   logic       pend_mode_q, pend_mode_d;
   logic [7:0] gap_q, gap_d;
   logic       run_q, run_d;
   logic       clear_q, clear_d;
   logic       mode_q, mode_d;
   logic       cmd_valid_q, cmd_valid_d;
   logic [1:0] cmd_q, cmd_d;

   uart_cmd_decode u_decode (
      .i_rx_data      (i_rx_data),
      .i_rx_done      (i_rx_done),
      .o_req_run_stop (uart_run_stop),
      .o_req_clear    (uart_clear),
      .o_req_mode     (uart_mode)
   );

   always_comb begin
      req_run_stop = i_btn_run_stop | uart_run_stop;
      req_clear    = i_btn_clear    | uart_clear;
      req_mode     = i_btn_mode     | uart_mode;

      // No issue while the spacing counter runs or during the CLEAR pulse cycle.
      can_issue      = (gap_q == 8'd0) && (state_q != ST_CLEAR);
      issue_clear    = can_issue && pend_clear_q;
      issue_run_stop = can_issue && pend_run_stop_q && !pend_clear_q;
      issue_mode     = can_issue && pend_mode_q && !pend_clear_q && !pend_run_stop_q;

      // A request arriving in the issue cycle re-arms the flag it just emptied.
      pend_clear_d    = (pend_clear_q    && !issue_clear)    || req_clear;
      pend_run_stop_d = (pend_run_stop_q && !issue_run_stop) || req_run_stop;
      pend_mode_d     = (pend_mode_q     && !issue_mode)     || req_mode;

      gap_d = gap_q;
      if (issue_clear || issue_run_stop || issue_mode) begin
         gap_d = GAP_LOAD;
      end else if (gap_q != 8'd0) begin
         gap_d = gap_q - 8'd1;
      end

      state_d = state_q;
      case (state_q)
         ST_STOP: begin
            if (issue_run_stop) begin
               state_d = ST_RUN;
            end else if (issue_clear) begin
               state_d = ST_CLEAR;
            end
         end
         ST_RUN: begin
            // A clear while running is consumed without leaving RUN.
            if (issue_run_stop) begin
               state_d = ST_STOP;
            end
         end
         ST_CLEAR: state_d = ST_STOP;
         default:  state_d = ST_STOP;
      endcase

      cmd_valid_d = issue_clear || issue_run_stop || issue_mode;
      cmd_d       = CMD_NONE;
      if (issue_clear) begin
         cmd_d = CMD_CLEAR;
      end else if (issue_run_stop) begin
         cmd_d = CMD_RUN_STOP;
      end else if (issue_mode) begin
         cmd_d = CMD_MODE;
      end

      // Outputs are registered from the next state so they align with it.
      run_d   = (state_d == ST_RUN);
      clear_d = (state_d == ST_CLEAR);
      mode_d  = mode_q ^ issue_mode;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_STOP;
         pend_run_stop_q <= 1'b0;
         pend_clear_q    <= 1'b0;
         pend_mode_q     <= 1'b0;
         gap_q           <= 8'd0;
         run_q           <= 1'b0;
         clear_q         <= 1'b0;
         mode_q          <= 1'b0;
         cmd_valid_q     <= 1'b0;
         cmd_q           <= CMD_NONE;
      end else begin
         state_q         <= state_d;
         pend_run_stop_q <= pend_run_stop_d;
         pend_clear_q    <= pend_clear_d;
         pend_mode_q     <= pend_mode_d;
         gap_q           <= gap_d;
         run_q           <= run_d;
         clear_q         <= clear_d;
         mode_q          <= mode_d;
         cmd_valid_q     <= cmd_valid_d;
         cmd_q           <= cmd_d;
      end
   end

   assign o_run       = run_q;
   assign o_clear     = clear_q;
   assign o_mode      = mode_q;
   assign o_cmd_valid = cmd_valid_q;
   assign o_cmd       = cmd_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_stopwatch_cmd_arbiter.sv
// Bench for stopwatch_cmd_arbiter (CMD_GAP=4).
// Stimulus drives directed pulses and pushes hand-computed expected issues
// {cycle, cmd, run, clear, mode} into exp_q. The monitor checks every cycle at
// the falling edge: an issue must match the head of exp_q exactly (including
// its cycle), and a non-issue cycle must show o_cmd=0, o_clear=0 and unchanged
// o_run/o_mode levels.
module tb_stopwatch_cmd_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_btn_run_stop = 1'b0;
   logic       i_btn_clear = 1'b0;
   logic       i_btn_mode = 1'b0;
   logic [7:0] i_rx_data = 8'h00;
   logic       i_rx_done = 1'b0;
   logic       o_run, o_clear, o_mode, o_cmd_valid;
   logic [1:0] o_cmd, o_dbg_state;

   logic [15:0] cyc = 16'd0;
   logic [20:0] exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic        last_run = 1'b0;
   logic        last_mode = 1'b0;

   stopwatch_cmd_arbiter #(.CMD_GAP(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_btn_run_stop (i_btn_run_stop),
      .i_btn_clear    (i_btn_clear),
      .i_btn_mode     (i_btn_mode),
      .i_rx_data      (i_rx_data),
      .i_rx_done      (i_rx_done),
      .o_run          (o_run),
      .o_clear        (o_clear),
      .o_mode         (o_mode),
      .o_cmd_valid    (o_cmd_valid),
      .o_cmd          (o_cmd),
      .o_dbg_state    (o_dbg_state)
   );

   // ---------------- clock / reset bookkeeping ----------------
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 16'd0;
      else     cyc <= cyc + 16'd1;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (int'(cyc) < n && guard < 2000) begin
         tick();
         guard++;
      end
   endtask

   task automatic drive(input logic rs, input logic clr, input logic md,
                        input logic [7:0] rx, input logic rxd);
      i_btn_run_stop = rs;
      i_btn_clear    = clr;
      i_btn_mode     = md;
      i_rx_data      = rx;
      i_rx_done      = rxd;
      tick();
      i_btn_run_stop = 1'b0;
      i_btn_clear    = 1'b0;
      i_btn_mode     = 1'b0;
      i_rx_data      = 8'h00;
      i_rx_done      = 1'b0;
   endtask

   task automatic push(input int c, input logic [1:0] cmd, input logic run,
                       input logic clr, input logic md);
      exp_q.push_back({16'(c), cmd, run, clr, md});
   endtask

   task automatic check_idle(input string name);
      logic [6:0] got;
      got = {o_run, o_clear, o_mode, o_cmd_valid, o_cmd, 1'b0} | {6'd0, |o_dbg_state};
      vectors++;
      if (got !== 7'd0) begin
         miscompares++;
         $display("FAIL %s: run=%b clear=%b mode=%b valid=%b cmd=%0d state=%0d, required all zero",
                  name, o_run, o_clear, o_mode, o_cmd_valid, o_cmd, o_dbg_state);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [20:0] e;
      logic [20:0] got;
      if (rst) begin
         last_run  = 1'b0;
         last_mode = 1'b0;
      end else if (o_cmd_valid) begin
         vectors++;
         got = {cyc, o_cmd, o_run, o_clear, o_mode};
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_issue: cyc=%0d cmd=%0d, required no issue", cyc, o_cmd);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               miscompares++;
               $display("FAIL issue: got cyc=%0d cmd=%0d run=%b clr=%b mode=%b, required cyc=%0d cmd=%0d run=%b clr=%b mode=%b",
                        got[20:5], got[4:3], got[2], got[1], got[0],
                        e[20:5], e[4:3], e[2], e[1], e[0]);
            end
            last_run  = e[2];
            last_mode = e[0];
         end
      end else begin
         vectors++;
         if ({o_cmd, o_clear, o_run, o_mode} !== {2'd0, 1'b0, last_run, last_mode}) begin
            miscompares++;
            $display("FAIL idle_outputs: cyc=%0d cmd=%0d clr=%b run=%b mode=%b, required cmd=0 clr=0 run=%b mode=%b",
                     cyc, o_cmd, o_clear, o_run, o_mode, last_run, last_mode);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int c;
      repeat (3) tick();
      check_idle("reset_outputs");
      rst = 1'b0;

      // run_stop button at cycle 10 -> RUN at 12
      wait_cyc(10); push(12, 2'd1, 1, 0, 0); drive(1, 0, 0, 8'h00, 0);
      // 'c' while running: consumed, stays in RUN
      wait_cyc(20); push(22, 2'd2, 1, 0, 0); drive(0, 0, 0, 8'h63, 1);
      // run_stop button -> STOP
      wait_cyc(30); push(32, 2'd1, 0, 0, 0); drive(1, 0, 0, 8'h00, 0);
      // all three buttons together in STOP: clear, run_stop, mode 4 cycles apart
      wait_cyc(40);
      push(42, 2'd2, 0, 1, 0);
      push(46, 2'd1, 1, 0, 0);
      push(50, 2'd3, 1, 0, 1);
      drive(1, 1, 1, 8'h00, 0);
      // mode button and 'M' in the same cycle -> one toggle
      wait_cyc(60); push(62, 2'd3, 1, 0, 0); drive(0, 0, 1, 8'h4D, 1);
      // unrecognised bytes
      wait_cyc(70); drive(0, 0, 0, 8'h41, 1); drive(0, 0, 0, 8'h00, 1);
      // remaining letters
      wait_cyc(80);  push(82,  2'd1, 0, 0, 0); drive(0, 0, 0, 8'h72, 1);
      wait_cyc(90);  push(92,  2'd2, 0, 1, 0); drive(0, 0, 0, 8'h43, 1);
      wait_cyc(100); push(102, 2'd3, 0, 0, 1); drive(0, 0, 0, 8'h6D, 1);
      wait_cyc(110); push(112, 2'd1, 1, 0, 1); drive(0, 0, 0, 8'h52, 1);
      // mode requests inside the gap merge; one on the issue cycle re-arms
      wait_cyc(120);
      push(122, 2'd3, 1, 0, 0);
      push(126, 2'd3, 1, 0, 1);
      push(130, 2'd3, 1, 0, 0);
      drive(0, 0, 1, 8'h00, 0);
      wait_cyc(123);
      drive(0, 0, 1, 8'h00, 0);
      drive(0, 0, 1, 8'h00, 0);
      drive(0, 0, 1, 8'h00, 0);
      // RUN with a pending mode flag, then one reset cycle with a request
      wait_cyc(140); push(142, 2'd3, 1, 0, 1); drive(0, 0, 1, 8'h00, 0);
      wait_cyc(143); drive(0, 0, 1, 8'h00, 0);
      rst = 1'b1;
      drive(1, 0, 0, 8'h00, 0);
      rst = 1'b0;
      check_idle("mid_reset_outputs");
      repeat (20) tick();
      // block works normally after the reset
      c = int'(cyc);
      push(c + 2, 2'd1, 1, 0, 0);
      drive(1, 0, 0, 8'h00, 0);
      repeat (10) tick();

      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_issues: %0d expected issues never seen, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stopwatch_cmd_arbiter.md
STOPWATCH_CMD_ARBITER -- requirements
Module: stopwatch_cmd_arbiter

Interface
REQ-001 Parameter CMD_GAP, default 4, SHALL set the minimum cycles between two issued commands; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 i_btn_run_stop  input  1  one-cycle pulse from the debounced run/stop button.
REQ-005 i_btn_clear  input  1  one-cycle pulse from the debounced clear button.
REQ-006 i_btn_mode  input  1  one-cycle pulse from the debounced mode button.
REQ-007 i_rx_data  input  8  UART received byte; valid only while i_rx_done=1.
REQ-008 i_rx_done  input  1  one-cycle strobe: UART byte received.
REQ-009 o_run  output  1  level; 1 = stopwatch counting.
REQ-010 o_clear  output  1  one-cycle pulse; clears the stopwatch count.
REQ-011 o_mode  output  1  level; display mode, toggles on each mode command.
REQ-012 o_cmd_valid  output  1  one-cycle pulse; a command was issued this cycle.
REQ-013 o_cmd  output  2  issued command code: 1 run_stop, 2 clear, 3 mode; 0 when o_cmd_valid=0.

Function
REQ-014 UART decode SHALL map 'R'/'r' (0x52/0x72) to run_stop, 'C'/'c' (0x43/0x63) to clear, and 'M'/'m' (0x4D/0x6D) to mode, only when i_rx_done=1; all other bytes SHALL be ignored.
REQ-015 Three pending flags (run_stop, clear, mode) SHALL be set at the clock edge ending a cycle in which a button pulse or decoded UART command for that command is present.
REQ-016 A request for a command whose flag is already set SHALL merge into that flag; button and UART requests for the same command in one cycle SHALL produce one pending command.
REQ-017 The block SHALL issue at most one command per cycle, in fixed priority clear > run_stop > mode.
REQ-018 Issue SHALL be allowed only when the gap counter is 0 and the FSM is not in CLEAR.
REQ-019 Issuing a command SHALL clear its flag, unless a new request for the same command arrives in that cycle, in which case the flag SHALL stay set.
REQ-020 After an issue at cycle t, the next issue SHALL occur no earlier than cycle t+CMD_GAP; the gap counter SHALL load CMD_GAP-1 on issue and decrement to 0.
REQ-021 Latency: a request in cycle n with an idle arbiter SHALL give o_cmd_valid=1 and the FSM/output update in cycle n+2.
REQ-022 FSM states SHALL be STOP, RUN and CLEAR.
REQ-023 STOP transitions: run_stop -> RUN; clear -> CLEAR.
REQ-024 RUN transitions: run_stop -> STOP; clear SHALL be consumed (flag cleared, o_cmd_valid pulsed) with no state change.
REQ-025 CLEAR SHALL last exactly one cycle with o_clear=1 and SHALL then return to STOP.
REQ-026 o_run SHALL be 1 only in RUN.
REQ-027 A mode command SHALL toggle o_mode in any state without changing the FSM state.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL set state STOP, clear all pending flags, and set the gap counter to 0.
REQ-030 During the same reset, the block SHALL drive o_run=0, o_clear=0, o_mode=0, o_cmd_valid=0 and o_cmd=0.
REQ-031 Reset asserted mid-operation, including in CLEAR or with pending flags set, SHALL discard all pending commands.
REQ-032 Requests present in the cycle rst=1 SHALL be dropped.

Structure
REQ-033 A shared package SHALL hold the command codes (CMD_NONE/RUN_STOP/CLEAR/MODE), the FSM state encoding and the six ASCII command constants.
REQ-034 UART decoding SHALL be a sub-module uart_cmd_decode (i_rx_data, i_rx_done -> three 1-bit request strobes); arbitration, gap counter and FSM stay in the top module.

Verification
REQ-035 After reset, i_btn_run_stop pulse in cycle 10 -> o_cmd_valid=1, o_cmd=1 and o_run=1 in cycle 12.
REQ-036 With CMD_GAP=4, i_btn_clear, i_btn_run_stop and i_btn_mode pulsed together in STOP -> issues at cycles t, t+4, t+8 in order clear (o_clear=1 one cycle), run_stop (o_run=1), mode (o_mode=1).
REQ-037 In RUN, send UART byte 0x63 -> o_cmd_valid=1 with o_cmd=2, o_clear stays 0 and o_run stays 1.
REQ-038 i_btn_mode and UART 0x4D in the same cycle -> exactly one mode issue, o_mode toggles once.
REQ-039 UART bytes 0x41 and 0x00 -> no o_cmd_valid; RUN with a pending mode flag and rst=1 for one cycle -> o_run=0 and no mode issue afterwards.
